// File: rtl/and_reduce_sched_pkg.sv
// Shared types for the round-robin AND-reduction scheduler.
// State encoding plus the byte-count width helper.
package and_reduce_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte counter must hold WORD_W/8 itself, hence the +1.
  function automatic int bytes_w(input int word_w);
    return $clog2(word_w / 8) + 1;
  endfunction

endpackage

// File: rtl/and_reduce_sched_and8.sv
// Shared 8-input AND reduction unit.
// One instance serves every requester, one byte per cycle.
module naive_AND8 (
  input  logic [7:0] In,
  output logic       Out
);

  assign Out = &In;

endmodule

// File: rtl/and_reduce_sched.sv
// Round-robin scheduler feeding one byte-serial AND reducer.
// Grants one operand, reduces LSB byte first, holds result.
module and_reduce_sched
  import and_reduce_sched_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int WORD_W     = 64,
  parameter int EARLY_EXIT = 1
) (
  input  logic                              Clk,
  input  logic                              Reset_n,
  input  logic [NUM_REQ-1:0]                Req_valid,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]    Req_data,
  output logic [NUM_REQ-1:0]                Req_ready,
  output logic                              Rsp_valid,
  input  logic                              Rsp_ready,
  output logic                              Rsp_result,
  output logic [$clog2(NUM_REQ)-1:0]        Rsp_id,
  output logic [bytes_w(WORD_W)-1:0]        Rsp_bytes,
  output logic                              Busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = bytes_w(WORD_W);
  localparam int NB = WORD_W / 8;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] op_q;
  logic [IW-1:0]     id_q, last_q, win;
  logic [BW-1:0]     idx_q;
  logic              acc_q;
  logic              any_req, hs, fin;
  logic              unit_out;
  int                cand;

  naive_AND8 u_and8 (
    .In  (op_q[7:0]),
    .Out (unit_out)
  );

  // Search starts one past the last grant.
  always_comb begin
    win     = last_q;
    any_req = 1'b0;
    cand    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_q) + i) % NUM_REQ;
      if (!any_req && Req_valid[cand]) begin
        any_req = 1'b1;
        win     = IW'(cand);
      end
    end
  end

  assign hs  = (state_q == IDLE) && any_req;
  assign fin = (idx_q == BW'(NB - 1)) ||
               ((EARLY_EXIT != 0) && !unit_out);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs)        state_d = RUN;
      RUN:     if (fin)       state_d = DONE;
      DONE:    if (Rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    Req_ready  = '0;
    if (hs && Reset_n) Req_ready[win] = 1'b1;
    Busy       = (state_q != IDLE);
    Rsp_valid  = (state_q == DONE);
    Rsp_result = Rsp_valid & acc_q;
    Rsp_id     = Rsp_valid ? id_q  : '0;
    Rsp_bytes  = Rsp_valid ? idx_q : '0;
  end

  // Operand shifts down so byte idx always sits in [7:0].
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      op_q   <= '0;
      id_q   <= '0;
      last_q <= IW'(NUM_REQ - 1);
      idx_q  <= '0;
      acc_q  <= 1'b1;
    end else if (hs) begin
      op_q   <= Req_data[win];
      id_q   <= win;
      last_q <= win;
      idx_q  <= '0;
      acc_q  <= 1'b1;
    end else if (state_q == RUN) begin
      op_q   <= op_q >> 8;
      idx_q  <= idx_q + 1'b1;
      acc_q  <= acc_q & unit_out;
    end
  end

endmodule

// File: doc/and_reduce_sched.md
AND_REDUCE_SCHED -- requirements
Module: and_reduce_sched

Interface
REQ-001 Parameter NUM_REQ, default 2, is the number of requesters sharing the reduction unit (legal range 2..8).
REQ-002 Parameter WORD_W, default 64, is the operand width in bits (multiple of 8, legal range 8..256).
REQ-003 Parameter EARLY_EXIT, default 1: when 1, the block terminates the reduction on the first all-zero-result byte.
REQ-004 Port: Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port: Reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port: Req_valid, input, NUM_REQ, per-requester operand-valid.
REQ-007 Port: Req_data, input, NUM_REQ x WORD_W, per-requester operand.
REQ-008 Port: Req_ready, output, NUM_REQ, per-requester accept; at most one bit high.
REQ-009 Port: Rsp_valid, output, 1, result available.
REQ-010 Port: Rsp_ready, input, 1, consumer accepts the result.
REQ-011 Port: Rsp_result, output, 1, AND-reduction of the granted operand.
REQ-012 Port: Rsp_id, output, clog2(NUM_REQ), index of the requester that owns the result.
REQ-013 Port: Rsp_bytes, output, clog2(WORD_W/8)+1, number of bytes passed through the unit.
REQ-014 Port: Busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 FSM states: IDLE, RUN, DONE.
REQ-016 IDLE: if any Req_valid is high, Req_ready asserts combinationally for the round-robin winner only; the handshake captures the operand and ID and moves to RUN.
REQ-017 Round-robin order: search starts at (last granted + 1) mod NUM_REQ; the pointer updates only on a handshake.
REQ-018 RUN: each cycle, byte idx (bits 8*idx+7..8*idx, LSB byte first) feeds one 8-input AND unit; acc <= acc & unit output; idx increments.
REQ-019 RUN -> DONE when idx reaches WORD_W/8-1, or when EARLY_EXIT=1 and the unit output is 0.
REQ-020 Latency: for a handshake at edge E0 with N bytes processed, Rsp_valid is high after edge E0+N; a full all-ones 64-bit word gives N=8.
REQ-021 DONE: Rsp_valid, Rsp_result, Rsp_id and Rsp_bytes stay stable until Rsp_ready is high at a rising edge; the state then returns to IDLE.
REQ-022 No new grant occurs in the cycle a response is consumed; the earliest next Req_ready is the cycle after.
REQ-023 Req_ready is 0 in RUN and DONE; Req_valid deassertion there has no effect.
REQ-024 Simultaneous Req_valid from all requesters is served in strict rotation, with no requester starved beyond NUM_REQ-1 intervening grants.

Reset
REQ-025 While Reset_n is low: state IDLE, Req_ready 0, Rsp_valid 0, Rsp_result 0, Rsp_id 0, Rsp_bytes 0, Busy 0, acc 1, idx 0, and the RR pointer set so requester 0 wins first.
REQ-026 Reset asserted mid-RUN or mid-DONE discards the operation silently; no response is produced for it after release.

Structure
REQ-027 A shared package holds the FSM state enum and the byte-count width helper constant.
REQ-028 The block instantiates exactly one 8-input AND reduction sub-module, naive_AND8 (ports In, Out), as its shared datapath.

Verification
REQ-029 Req0 valid, data 64'hFFFF_FFFF_FFFF_FFFF, Rsp_ready=1 -> Rsp_valid 8 cycles after the handshake, result 1, id 0, bytes 8.
REQ-030 EARLY_EXIT=1, Req1 data 64'hFFFF_FFFF_FF00_FFFF -> result 0, id 1, bytes 3, Rsp_valid 3 cycles after the handshake.
REQ-031 Both requesters valid continuously with all-ones data -> grants alternate 0,1,0,1 over 4 responses.
REQ-032 Rsp_ready held 0 for 5 cycles in DONE -> outputs stable, no Req_ready pulse; release -> next grant the following cycle.
REQ-033 Reset_n pulsed low during RUN at byte 4 -> Busy 0 immediately, no Rsp_valid, and the next grant goes to requester 0.
REQ-034 10000 random operands and random Rsp_ready -> every Rsp_result equals &operand of the matching Rsp_id, with no lost or duplicated responses.
